// File: rtl/cpu7_exu_wbarb.sv
// Integer register-file write-port arbiter: LSU load returns beat a small ALU result FIFO.
// Also holds the pending-load scoreboard that drives the decode-stage interlock.
module cpu7_exu_wbarb #(
   parameter int GRLEN    = 32,
   parameter int AQ_DEPTH = 2,
   parameter int LD_MAX   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_wb_valid_m,
   input  logic [4:0]       alu_wb_rd_m,
   input  logic [GRLEN-1:0] alu_wb_data_m,
   input  logic [GRLEN-1:0] alu_wb_pc_m,
   output logic             wbarb_alu_ready_m,
   input  logic             lsu_wb_valid_m,
   input  logic [4:0]       lsu_wb_rd_m,
   input  logic [GRLEN-1:0] lsu_wb_data_m,
   input  logic [GRLEN-1:0] lsu_wb_pc_m,
   input  logic             load_issue_e,
   input  logic [4:0]       load_rd_e,
   input  logic             dec_valid_d,
   input  logic [4:0]       dec_rs1_d,
   input  logic [4:0]       dec_rs2_d,
   input  logic [4:0]       dec_rd_d,
   input  logic             dec_is_load_d,
   output logic             wbarb_stall_d,
   output logic             wbarb_irf_wen_w,
   output logic [4:0]       wbarb_irf_rd_w,
   output logic [GRLEN-1:0] wbarb_irf_data_w,
   output logic [GRLEN-1:0] wbarb_pc_w,
   output logic             wbarb_err
);
   localparam int PW = (AQ_DEPTH > 1) ? $clog2(AQ_DEPTH) : 1;
   localparam int CW = $clog2(AQ_DEPTH + 1);
   localparam int LW = $clog2(LD_MAX + 1);

   typedef struct packed {
      logic [4:0]       rd;
      logic [GRLEN-1:0] data;
      logic [GRLEN-1:0] pc;
   } aq_ent_t;

   aq_ent_t          aq_q   [AQ_DEPTH];
   aq_ent_t          aq_d   [AQ_DEPTH];
   logic             vld_q  [AQ_DEPTH];
   logic             vld_d  [AQ_DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [31:0]      pend_q, pend_d;
   logic [LW-1:0]    ldcnt_q, ldcnt_d;
   logic             err_q, err_d;
   logic             wen_q, wen_d;
   logic [4:0]       rd_q, rd_d;
   logic [GRLEN-1:0] data_q, data_d, pc_q, pc_d;

   logic             alu_push, aq_pop, ld_full, ld_hit, ld_inc;
   logic             sb_hit, aq_hit;
   aq_ent_t          head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(AQ_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic rd_match(input logic [4:0] r, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
      return (r != 5'd0) && ((r == a) || (r == b) || (r == c));
   endfunction

   assign wbarb_alu_ready_m = (cnt_q < CW'(AQ_DEPTH));

   always_comb begin
      aq_d     = aq_q;
      vld_d    = vld_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      head     = aq_q[rptr_q];
      alu_push = alu_wb_valid_m & wbarb_alu_ready_m;
      aq_pop   = ~lsu_wb_valid_m & (cnt_q != '0);
      if (alu_push) begin
         aq_d[wptr_q]  = '{rd: alu_wb_rd_m, data: alu_wb_data_m, pc: alu_wb_pc_m};
         vld_d[wptr_q] = 1'b1;
         wptr_d        = ptr_inc(wptr_q);
      end
      if (aq_pop) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = ptr_inc(rptr_q);
      end
      cnt_d = cnt_q + CW'(alu_push) - CW'(aq_pop);

      // rd==0 still occupies the port and updates rd/data/pc; only the enable is suppressed.
      wen_d  = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      pc_d   = pc_q;
      if (lsu_wb_valid_m) begin
         wen_d  = (lsu_wb_rd_m != 5'd0);
         rd_d   = lsu_wb_rd_m;
         data_d = lsu_wb_data_m;
         pc_d   = lsu_wb_pc_m;
      end else if (aq_pop) begin
         wen_d  = (head.rd != 5'd0);
         rd_d   = head.rd;
         data_d = head.data;
         pc_d   = head.pc;
      end
   end

   always_comb begin
      ld_full = (ldcnt_q == LW'(LD_MAX));
      ld_hit  = lsu_wb_valid_m & pend_q[lsu_wb_rd_m];
      // An issue at the limit only counts if a return frees a slot in the same cycle.
      ld_inc  = load_issue_e & (~ld_full | ld_hit);
      ldcnt_d = ldcnt_q + LW'(ld_inc) - LW'(ld_hit);
      pend_d  = pend_q;
      if (lsu_wb_valid_m) pend_d[lsu_wb_rd_m] = 1'b0;
      if (load_issue_e)   pend_d[load_rd_e]   = 1'b1;
      pend_d[0] = 1'b0;
      err_d = err_q
            | (lsu_wb_valid_m & ~pend_q[lsu_wb_rd_m])
            | (load_issue_e & ld_full & ~ld_hit);
   end

   // The entry sitting in the _w stage has already left pend_q and the FIFO;
   // register-file write-through serves a decode read of it, so it never stalls.
   always_comb begin
      sb_hit = pend_q[dec_rs1_d] | pend_q[dec_rs2_d] | pend_q[dec_rd_d];
      aq_hit = 1'b0;
      for (int i = 0; i < AQ_DEPTH; i++) begin
         if (vld_q[i] && rd_match(aq_q[i].rd, dec_rs1_d, dec_rs2_d, dec_rd_d))
            aq_hit = 1'b1;
      end
      wbarb_stall_d = dec_valid_d & (sb_hit | aq_hit | (dec_is_load_d & ld_full));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < AQ_DEPTH; i++) begin
            aq_q[i]  <= '0;
            vld_q[i] <= 1'b0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
         ldcnt_q <= '0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         aq_q    <= aq_d;
         vld_q   <= vld_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ldcnt_q <= ldcnt_d;
         err_q   <= err_d;
         wen_q   <= wen_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign wbarb_irf_wen_w  = wen_q;
   assign wbarb_irf_rd_w   = rd_q;
   assign wbarb_irf_data_w = data_q;
   assign wbarb_pc_w       = pc_q;
   assign wbarb_err        = err_q;

endmodule

// File: tb/tb_cpu7_exu_wbarb.sv
// Directed bench for cpu7_exu_wbarb: expected writebacks queued at issue, checked by a cycle-tagged monitor.
module tb_cpu7_exu_wbarb;
   logic        clk = 1'b0;
   logic        reset;
   logic        alu_wb_valid_m, lsu_wb_valid_m, load_issue_e;
   logic [4:0]  alu_wb_rd_m, lsu_wb_rd_m, load_rd_e;
   logic [31:0] alu_wb_data_m, alu_wb_pc_m, lsu_wb_data_m, lsu_wb_pc_m;
   logic        dec_valid_d, dec_is_load_d;
   logic [4:0]  dec_rs1_d, dec_rs2_d, dec_rd_d;
   logic        wbarb_alu_ready_m, wbarb_stall_d, wbarb_irf_wen_w, wbarb_err;
   logic [4:0]  wbarb_irf_rd_w;
   logic [31:0] wbarb_irf_data_w, wbarb_pc_w;

   cpu7_exu_wbarb #(.GRLEN(32), .AQ_DEPTH(2), .LD_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .alu_wb_valid_m(alu_wb_valid_m), .alu_wb_rd_m(alu_wb_rd_m),
      .alu_wb_data_m(alu_wb_data_m), .alu_wb_pc_m(alu_wb_pc_m),
      .wbarb_alu_ready_m(wbarb_alu_ready_m),
      .lsu_wb_valid_m(lsu_wb_valid_m), .lsu_wb_rd_m(lsu_wb_rd_m),
      .lsu_wb_data_m(lsu_wb_data_m), .lsu_wb_pc_m(lsu_wb_pc_m),
      .load_issue_e(load_issue_e), .load_rd_e(load_rd_e),
      .dec_valid_d(dec_valid_d), .dec_rs1_d(dec_rs1_d), .dec_rs2_d(dec_rs2_d),
      .dec_rd_d(dec_rd_d), .dec_is_load_d(dec_is_load_d),
      .wbarb_stall_d(wbarb_stall_d),
      .wbarb_irf_wen_w(wbarb_irf_wen_w), .wbarb_irf_rd_w(wbarb_irf_rd_w),
      .wbarb_irf_data_w(wbarb_irf_data_w), .wbarb_pc_w(wbarb_pc_w),
      .wbarb_err(wbarb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (wbarb_irf_wen_w !== e.wen || wbarb_irf_rd_w !== e.rd ||
                wbarb_irf_data_w !== e.data || wbarb_pc_w !== e.pc) begin
               errors++;
               $display("FAIL wb@%0d: got wen=%0b rd=%0d data=%h pc=%h, want wen=%0b rd=%0d data=%h pc=%h",
                        cyc, wbarb_irf_wen_w, wbarb_irf_rd_w, wbarb_irf_data_w, wbarb_pc_w,
                        e.wen, e.rd, e.data, e.pc);
            end
         end else if (wbarb_irf_wen_w) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb@%0d: got wen=1 rd=%0d data=%h, want no write",
                     cyc, wbarb_irf_rd_w, wbarb_irf_data_w);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      alu_wb_valid_m = 0; alu_wb_rd_m = 0; alu_wb_data_m = 0; alu_wb_pc_m = 0;
      lsu_wb_valid_m = 0; lsu_wb_rd_m = 0; lsu_wb_data_m = 0; lsu_wb_pc_m = 0;
      load_issue_e = 0; load_rd_e = 0;
      dec_valid_d = 0; dec_rs1_d = 0; dec_rs2_d = 0; dec_rd_d = 0; dec_is_load_d = 0;
   endtask

   task automatic alu(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
      alu_wb_valid_m = 1; alu_wb_rd_m = r; alu_wb_data_m = d; alu_wb_pc_m = p;
   endtask

   task automatic lsu(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
      lsu_wb_valid_m = 1; lsu_wb_rd_m = r; lsu_wb_data_m = d; lsu_wb_pc_m = p;
   endtask

   task automatic ld(input logic [4:0] r);
      load_issue_e = 1; load_rd_e = r;
   endtask

   task automatic dec(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] r, input logic isld);
      dec_valid_d = 1; dec_rs1_d = s1; dec_rs2_d = s2; dec_rd_d = r; dec_is_load_d = isld;
   endtask

   task automatic expw(input int c, input logic w, input logic [4:0] r,
                       input logic [31:0] d, input logic [31:0] p);
      exp_t x;
      x.cyc = c; x.wen = w; x.rd = r; x.data = d; x.pc = p;
      q.push_back(x);
   endtask

   task automatic chk1(input string nm, input logic act, input logic expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s @%0d: got %b want %b", nm, cyc, act, expv);
      end
   endtask

   initial begin
      clr();
      reset = 1;
      step(); step();
      reset = 0;
      chk1("rst_wen", wbarb_irf_wen_w, 1'b0);
      chk1("rst_rd0", (wbarb_irf_rd_w == 5'd0) && (wbarb_irf_data_w == 32'd0) && (wbarb_pc_w == 32'd0), 1'b1);
      chk1("rst_err", wbarb_err, 1'b0);
      chk1("rst_ready", wbarb_alu_ready_m, 1'b1);
      chk1("rst_stall", wbarb_stall_d, 1'b0);

      // ALU only, including an rd==0 result that must not enable the write.
      step(); alu(5'd5, 32'h11, 32'h100); #1;
      chk1("t1_ready0", wbarb_alu_ready_m, 1'b1);
      expw(cyc + 2, 1'b1, 5'd5, 32'h11, 32'h100);
      expw(cyc + 3, 1'b0, 5'd0, 32'h22, 32'h104);
      expw(cyc + 4, 1'b0, 5'd0, 32'h22, 32'h104);
      step(); alu(5'd0, 32'h22, 32'h104); #1;
      chk1("t1_ready1", wbarb_alu_ready_m, 1'b1);
      step(); clr(); #1;
      chk1("t1_ready2", wbarb_alu_ready_m, 1'b1);
      repeat (4) step();

      // Collision: load return wins, ALU result follows one cycle later.
      ld(5'd3);
      step(); clr(); lsu(5'd3, 32'hAA, 32'h200); alu(5'd4, 32'hBB, 32'h204);
      expw(cyc + 1, 1'b1, 5'd3, 32'hAA, 32'h200);
      expw(cyc + 2, 1'b1, 5'd4, 32'hBB, 32'h204);
      step(); clr();
      repeat (4) step();

      // FIFO full behind three back-to-back load returns.
      ld(5'd10); step(); ld(5'd11); step(); ld(5'd12); step(); clr();
      lsu(5'd10, 32'hA0, 32'h300); alu(5'd20, 32'hC0, 32'h310);
      expw(cyc + 1, 1'b1, 5'd10, 32'hA0, 32'h300);
      expw(cyc + 2, 1'b1, 5'd11, 32'hA1, 32'h304);
      expw(cyc + 3, 1'b1, 5'd12, 32'hA2, 32'h308);
      expw(cyc + 4, 1'b1, 5'd20, 32'hC0, 32'h310);
      expw(cyc + 5, 1'b1, 5'd21, 32'hC1, 32'h314);
      step(); clr(); lsu(5'd11, 32'hA1, 32'h304); alu(5'd21, 32'hC1, 32'h314);
      dec(5'd0, 5'd20, 5'd0, 1'b0); #1;
      chk1("t3_ready_one", wbarb_alu_ready_m, 1'b1);
      chk1("t3_fifo_stall", wbarb_stall_d, 1'b1);
      step(); clr(); lsu(5'd12, 32'hA2, 32'h308); alu(5'd22, 32'hEE, 32'h318); #1;
      chk1("t3_ready_full", wbarb_alu_ready_m, 1'b0);
      step(); clr(); #1;
      chk1("t3_ready_popcyc", wbarb_alu_ready_m, 1'b0);
      step(); #1;
      chk1("t3_ready_back", wbarb_alu_ready_m, 1'b1);
      repeat (4) step();

      // Load-use interlock on r7.
      ld(5'd7);
      step(); clr(); dec(5'd7, 5'd1, 5'd2, 1'b0); #1;
      chk1("t4_stall_pend", wbarb_stall_d, 1'b1);
      dec_valid_d = 0; #1;
      chk1("t4_no_valid", wbarb_stall_d, 1'b0);
      dec(5'd0, 5'd0, 5'd0, 1'b0); #1;
      chk1("t4_rs_zero", wbarb_stall_d, 1'b0);
      step(); dec(5'd7, 5'd1, 5'd2, 1'b0); #1;
      chk1("t4_stall_hold", wbarb_stall_d, 1'b1);
      step(); lsu(5'd7, 32'h77, 32'h400); #1;
      expw(cyc + 1, 1'b1, 5'd7, 32'h77, 32'h400);
      chk1("t4_stall_retcyc", wbarb_stall_d, 1'b1);
      step(); lsu_wb_valid_m = 0; #1;
      chk1("t4_stall_release", wbarb_stall_d, 1'b0);
      step(); clr();
      repeat (3) step();

      // Outstanding-load limit.
      ld(5'd13); step(); ld(5'd14); step(); ld(5'd15); step(); ld(5'd16); step(); clr();
      dec(5'd1, 5'd2, 5'd17, 1'b1); #1;
      chk1("t5_ldmax_stall", wbarb_stall_d, 1'b1);
      dec_is_load_d = 0; #1;
      chk1("t5_nonload_ok", wbarb_stall_d, 1'b0);
      dec_is_load_d = 1;
      step(); lsu(5'd13, 32'h13, 32'h500); #1;
      expw(cyc + 1, 1'b1, 5'd13, 32'h13, 32'h500);
      expw(cyc + 2, 1'b1, 5'd14, 32'h14, 32'h504);
      expw(cyc + 3, 1'b1, 5'd15, 32'h15, 32'h508);
      expw(cyc + 4, 1'b1, 5'd16, 32'h16, 32'h50C);
      chk1("t5_stall_retcyc", wbarb_stall_d, 1'b1);
      step(); lsu(5'd14, 32'h14, 32'h504); #1;
      chk1("t5_stall_release", wbarb_stall_d, 1'b0);
      step(); clr(); lsu(5'd15, 32'h15, 32'h508);
      step(); lsu(5'd16, 32'h16, 32'h50C);
      step(); clr(); #1;
      chk1("t5_err_clean", wbarb_err, 1'b0);
      repeat (3) step();

      // Spurious return, then reset with ALU results stranded in the FIFO.
      lsu(5'd9, 32'h99, 32'h600);
      expw(cyc + 1, 1'b1, 5'd9, 32'h99, 32'h600);
      step(); clr(); #1;
      chk1("t6_err_set", wbarb_err, 1'b1);
      step(); step(); #1;
      chk1("t6_err_sticky", wbarb_err, 1'b1);
      lsu(5'd9, 32'h1, 32'h700); alu(5'd25, 32'h25, 32'h710);
      expw(cyc + 1, 1'b1, 5'd9, 32'h1, 32'h700);
      step(); lsu(5'd9, 32'h2, 32'h704); alu(5'd26, 32'h26, 32'h714); #1;
      chk1("t6_fifo_loaded", wbarb_alu_ready_m, 1'b1);
      step(); clr(); reset = 1;
      step(); reset = 0;
      expw(cyc,     1'b0, 5'd0, 32'h0, 32'h0);
      expw(cyc + 1, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk1("t6_err_reset", wbarb_err, 1'b0);
      chk1("t6_ready_reset", wbarb_alu_ready_m, 1'b1);
      repeat (5) step();

      chk1("queue_drained", q.size() == 0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
